// File: rtl/ahb_arbiter_if.sv
// Arbiter-side bundle of the shared AHB control signals: requests/locks in,
// grants and owner indices out.
interface ahb_arbiter_if #(
  parameter int unsigned MASTER_NUM       = 4,
  parameter int unsigned MASTER_IDX_WIDTH = 2
);
  logic [MASTER_NUM-1:0]       ahb_req_in;
  logic [MASTER_NUM-1:0]       ahb_lock_in;
  logic [1:0]                  ahb_trans_in;
  logic [2:0]                  ahb_burst_in;
  logic                        ahb_ready_in;
  logic [MASTER_NUM-1:0]       ahb_grant_out;
  logic [MASTER_IDX_WIDTH-1:0] ahb_master_out;
  logic [MASTER_IDX_WIDTH-1:0] ahb_data_master_out;
  logic                        ahb_mastlock_out;

  modport slave (
    input  ahb_req_in, ahb_lock_in, ahb_trans_in, ahb_burst_in, ahb_ready_in,
    output ahb_grant_out, ahb_master_out, ahb_data_master_out, ahb_mastlock_out
  );

  modport master (
    output ahb_req_in, ahb_lock_in, ahb_trans_in, ahb_burst_in, ahb_ready_in,
    input  ahb_grant_out, ahb_master_out, ahb_data_master_out, ahb_mastlock_out
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter that re-arbitrates only at transfer boundaries that are
// legal for the current owner (single/INCR beats, fixed-burst end, IDLE, lock release).
module ahb_arbiter #(
  parameter int unsigned MASTER_NUM       = 4,
  parameter int unsigned MASTER_IDX_WIDTH = 2,
  parameter int unsigned DEFAULT_MASTER   = 0
) (
  input logic           ahb_clk_in,
  input logic           ahb_rst_in,
  ahb_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [1:0]  HTRANS_IDLE   = 2'd0;
  localparam logic [1:0]  HTRANS_BUSY   = 2'd1;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0]  HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                      state_q, state_n;
  logic [CNT_W-1:0]            cnt_q, cnt_n;
  logic [MASTER_NUM-1:0]       grant_q, grant_n;
  logic [MASTER_IDX_WIDTH-1:0] master_q, master_n;
  logic [MASTER_IDX_WIDTH-1:0] data_master_q, data_master_n;
  logic                        mastlock_q, mastlock_n;

  logic [MASTER_NUM-1:0]       rot;
  logic [MASTER_IDX_WIDTH-1:0] sel;
  int                          off;
  logic                        any_req;
  logic [CNT_W-1:0]            len_m1;
  logic                        fixed_burst;
  logic                        owner_lock;
  logic                        do_open;
  logic                        do_rearb;

  // Rotate requests so bit 0 is the master after the current owner; first set bit wins.
  always_comb begin
    rot     = MASTER_NUM'({bus.ahb_req_in, bus.ahb_req_in} >> (int'(master_q) + 1));
    off     = 0;
    any_req = 1'b0;
    for (int k = 0; k < int'(MASTER_NUM); k++) begin
      if (!any_req && rot[k]) begin
        off     = k;
        any_req = 1'b1;
      end
    end
    sel = any_req ? MASTER_IDX_WIDTH'((int'(master_q) + 1 + off) % int'(MASTER_NUM))
                  : MASTER_IDX_WIDTH'(DEFAULT_MASTER);
  end

  always_comb begin
    case (bus.ahb_burst_in)
      3'd2, 3'd3: len_m1 = CNT_W'(3);
      3'd4, 3'd5: len_m1 = CNT_W'(7);
      3'd6, 3'd7: len_m1 = CNT_W'(15);
      default:    len_m1 = CNT_W'(0);
    endcase
    fixed_burst = (len_m1 != CNT_W'(0));
    owner_lock  = bus.ahb_lock_in[master_q];
  end

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    grant_n       = grant_q;
    master_n      = master_q;
    data_master_n = data_master_q;
    mastlock_n    = mastlock_q;
    do_open       = 1'b0;
    do_rearb      = 1'b0;

    if (bus.ahb_ready_in) begin
      data_master_n = master_q;
      case (state_q)
        ST_OPEN: do_open = 1'b1;
        ST_BURST: begin
          case (bus.ahb_trans_in)
            HTRANS_SEQ: begin
              cnt_n = cnt_q - CNT_W'(1);
              if (cnt_q == CNT_W'(1)) begin
                if (owner_lock) begin
                  state_n    = ST_LOCKED;
                  mastlock_n = 1'b1;
                end else begin
                  do_rearb = 1'b1;
                end
              end
            end
            HTRANS_BUSY: begin
            end
            default: begin
              // Early termination: re-evaluate as if the burst never started.
              cnt_n   = CNT_W'(0);
              do_open = 1'b1;
            end
          endcase
        end
        ST_LOCKED: begin
          // Track fixed bursts inside the lock so release waits for the last beat.
          if (bus.ahb_trans_in == HTRANS_SEQ && cnt_q != CNT_W'(0)) begin
            cnt_n = cnt_q - CNT_W'(1);
          end else if (bus.ahb_trans_in == HTRANS_NONSEQ) begin
            cnt_n = len_m1;
          end else if (bus.ahb_trans_in == HTRANS_IDLE) begin
            cnt_n = CNT_W'(0);
          end
          if (owner_lock) begin
            mastlock_n = (bus.ahb_trans_in != HTRANS_IDLE);
          end else if (cnt_q == CNT_W'(0) && bus.ahb_trans_in != HTRANS_BUSY) begin
            do_rearb = 1'b1;
          end
        end
        default: state_n = ST_OPEN;
      endcase

      if (do_open) begin
        if (bus.ahb_trans_in == HTRANS_NONSEQ && fixed_burst) begin
          cnt_n   = len_m1;
          state_n = ST_BURST;
        end else if (owner_lock) begin
          state_n    = ST_LOCKED;
          mastlock_n = 1'b1;
        end else begin
          do_rearb = 1'b1;
        end
      end

      if (do_rearb) begin
        state_n    = ST_OPEN;
        cnt_n      = CNT_W'(0);
        grant_n    = MASTER_NUM'(1) << sel;
        master_n   = sel;
        mastlock_n = 1'b0;
      end
    end
  end

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_q       <= ST_OPEN;
      cnt_q         <= CNT_W'(0);
      grant_q       <= MASTER_NUM'(1) << DEFAULT_MASTER;
      master_q      <= MASTER_IDX_WIDTH'(DEFAULT_MASTER);
      data_master_q <= MASTER_IDX_WIDTH'(DEFAULT_MASTER);
      mastlock_q    <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      grant_q       <= grant_n;
      master_q      <= master_n;
      data_master_q <= data_master_n;
      mastlock_q    <= mastlock_n;
    end
  end

  assign bus.ahb_grant_out       = grant_q;
  assign bus.ahb_master_out      = master_q;
  assign bus.ahb_data_master_out = data_master_q;
  assign bus.ahb_mastlock_out    = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus randomized traffic compared
// against a transaction-level model of owner, remaining beats and lock status.
module tb_ahb_arbiter;
  localparam int unsigned N = 4;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Model of the bus ownership as seen from outside
  int m_owner, m_beats, m_data;
  bit m_locked, m_mlock;

  ahb_arbiter_if #(.MASTER_NUM(N), .MASTER_IDX_WIDTH(2)) bus ();

  ahb_arbiter #(.MASTER_NUM(N), .MASTER_IDX_WIDTH(2), .DEFAULT_MASTER(0)) dut (
    .ahb_clk_in (clk),
    .ahb_rst_in (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic r, input logic rdy, input logic [3:0] req,
                       input logic [3:0] lock, input logic [1:0] tr, input logic [2:0] bu);
    rst              = r;
    bus.ahb_ready_in = rdy;
    bus.ahb_req_in   = req;
    bus.ahb_lock_in  = lock;
    bus.ahb_trans_in = tr;
    bus.ahb_burst_in = bu;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic rdy, input logic [3:0] req,
                            input logic [3:0] lock, input logic [1:0] tr, input logic [2:0] bu);
    int prev, old_beats, len, pick;
    bit open_eval, arb, own_lock, found;
    if (r) begin
      m_owner = 0; m_beats = 0; m_locked = 0; m_mlock = 0; m_data = 0;
      return;
    end
    if (!rdy) return;
    len       = (bu >= 3'd2) ? (4 << ((int'(bu) - 2) / 2)) : 0;
    own_lock  = ((lock >> m_owner) & 4'd1) != 4'd0;
    prev      = m_owner;
    old_beats = m_beats;
    open_eval = 0;
    arb       = 0;
    if (m_locked) begin
      if (tr == SEQ && old_beats > 0) m_beats = old_beats - 1;
      else if (tr == NONSEQ)          m_beats = (len > 0) ? len - 1 : 0;
      else if (tr == IDLE)            m_beats = 0;
      if (own_lock) m_mlock = (tr != IDLE);
      else if (old_beats == 0 && tr != BUSY) arb = 1;
    end else if (old_beats > 0) begin
      if (tr == SEQ) begin
        m_beats = old_beats - 1;
        if (m_beats == 0) begin
          if (own_lock) begin m_locked = 1; m_mlock = 1; end
          else arb = 1;
        end
      end else if (tr != BUSY) begin
        m_beats   = 0;
        open_eval = 1;
      end
    end else begin
      open_eval = 1;
    end
    if (open_eval) begin
      if (tr == NONSEQ && len > 0) m_beats = len - 1;
      else if (own_lock) begin m_locked = 1; m_mlock = 1; end
      else arb = 1;
    end
    if (arb) begin
      found = 0;
      pick  = 0;
      for (int d = 1; d <= int'(N); d++) begin
        if (!found && ((req >> ((m_owner + d) % int'(N))) & 4'd1) != 4'd0) begin
          pick  = (m_owner + d) % int'(N);
          found = 1;
        end
      end
      m_owner = pick; m_locked = 0; m_mlock = 0; m_beats = 0;
    end
    m_data = prev;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, IDLE, SINGLE);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.ahb_grant_out !== 4'b0001 || bus.ahb_master_out !== 2'd0 ||
          bus.ahb_data_master_out !== 2'd0 || bus.ahb_mastlock_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: grant=%b master=%0d data=%0d lock=%b, want 0001/0/0/0",
                 i, bus.ahb_grant_out, bus.ahb_master_out, bus.ahb_data_master_out, bus.ahb_mastlock_out);
      end
      cycle(1'b0, 1'b1, 4'b0000, 4'b0000, IDLE, SINGLE);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [3] = '{4'b0010, 4'b0100, 4'b0010};
    logic [1:0] exp_m [3] = '{2'd1, 2'd2, 2'd1};
    logic [1:0] exp_d [3] = '{2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 4'b0110, 4'b0000, NONSEQ, SINGLE);
      checks++;
      if (bus.ahb_grant_out !== exp_g[i] || bus.ahb_master_out !== exp_m[i] ||
          bus.ahb_data_master_out !== exp_d[i]) begin
        errors++;
        $display("FAIL round_robin step=%0d: grant=%b master=%0d data=%0d, want %b/%0d/%0d",
                 i, bus.ahb_grant_out, bus.ahb_master_out, bus.ahb_data_master_out,
                 exp_g[i], exp_m[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_incr4_stall();
    logic       rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] tr    [7] = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ, IDLE};
    logic [3:0] req   [7] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100};
    logic [3:0] exp_g [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    logic [1:0] exp_d [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, rdy[i], req[i], 4'b0000, tr[i], INCR4);
      checks++;
      if (bus.ahb_grant_out !== exp_g[i] || bus.ahb_data_master_out !== exp_d[i]) begin
        errors++;
        $display("FAIL incr4_stall step=%0d: grant=%b data=%0d, want %b/%0d",
                 i, bus.ahb_grant_out, bus.ahb_data_master_out, exp_g[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_incr8_busy_idle();
    logic [1:0] tr    [9] = '{IDLE, NONSEQ, SEQ, SEQ, BUSY, SEQ, SEQ, IDLE, IDLE};
    logic [3:0] req   [9] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
    logic [3:0] exp_g [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, req[i], 4'b0000, tr[i], INCR8);
      checks++;
      if (bus.ahb_grant_out !== exp_g[i]) begin
        errors++;
        $display("FAIL incr8_busy_idle step=%0d: grant=%b, want %b", i, bus.ahb_grant_out, exp_g[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [3:0] req   [7] = '{4'b0100, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    logic [3:0] lock  [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [1:0] tr    [7] = '{IDLE, NONSEQ, NONSEQ, NONSEQ, NONSEQ, IDLE, NONSEQ};
    logic [3:0] exp_g [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    logic       exp_l [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, req[i], lock[i], tr[i], SINGLE);
      checks++;
      if (bus.ahb_grant_out !== exp_g[i] || bus.ahb_mastlock_out !== exp_l[i]) begin
        errors++;
        $display("FAIL lock step=%0d: grant=%b mastlock=%b, want %b/%b",
                 i, bus.ahb_grant_out, bus.ahb_mastlock_out, exp_g[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 4'b1001, 4'b0000, (i == 0) ? NONSEQ : SEQ, INCR16);
      checks++;
      if (bus.ahb_grant_out !== 4'b1000) begin
        errors++;
        $display("FAIL incr16_hold step=%0d: grant=%b, want 1000", i, bus.ahb_grant_out);
      end
    end
    cycle(1'b1, 1'b1, 4'b1001, 4'b0000, SEQ, INCR16);
    checks++;
    if (bus.ahb_grant_out !== 4'b0001 || bus.ahb_master_out !== 2'd0 ||
        bus.ahb_data_master_out !== 2'd0 || bus.ahb_mastlock_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: grant=%b master=%0d data=%0d lock=%b, want 0001/0/0/0",
               bus.ahb_grant_out, bus.ahb_master_out, bus.ahb_data_master_out, bus.ahb_mastlock_out);
    end
    // A stray SEQ must not be treated as a burst beat once reset has cleared the burst
    cycle(1'b0, 1'b1, 4'b0010, 4'b0000, SEQ, INCR16);
    checks++;
    if (bus.ahb_grant_out !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_open: grant=%b, want 0010", bus.ahb_grant_out);
    end
  endtask

  task automatic test_random();
    logic       r, rdy;
    logic [3:0] req, lock;
    logic [1:0] tr;
    logic [2:0] bu;
    lock = 4'b0000;
    model_step(1'b1, 1'b1, 4'b0000, 4'b0000, IDLE, SINGLE);
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, IDLE, SINGLE);
    for (int i = 0; i < 1500; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      req  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lock = 4'($urandom) & 4'($urandom);
      bu   = 3'($urandom_range(0, 7));
      if (m_beats > 0 && $urandom_range(0, 9) < 7) tr = SEQ;
      else tr = 2'($urandom_range(0, 3));
      model_step(r, rdy, req, lock, tr, bu);
      cycle(r, rdy, req, lock, tr, bu);
      checks++;
      if (bus.ahb_grant_out !== (4'b0001 << m_owner) || bus.ahb_master_out !== 2'(m_owner) ||
          bus.ahb_data_master_out !== 2'(m_data) || bus.ahb_mastlock_out !== m_mlock) begin
        errors++;
        $display("FAIL random cyc=%0d: grant=%b master=%0d data=%0d lock=%b, want %b/%0d/%0d/%b",
                 i, bus.ahb_grant_out, bus.ahb_master_out, bus.ahb_data_master_out,
                 bus.ahb_mastlock_out, 4'b0001 << m_owner, m_owner, m_data, m_mlock);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_incr4_stall();
    test_incr8_busy_idle();
    test_lock();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares one AHB address/data path between MASTER_NUM ahb_master_if instances.
- Tracks the transfer type and burst of the current owner. Re-arbitrates only at legal points: single, INCR beat, burst end, IDLE, or lock release.
- Drives one-hot grants plus address-phase and data-phase owner indices, which the bus mux uses to steer HADDR/HWDATA/HRDATA.

Parameters:
MASTER_NUM, 4, number of requesting masters (2..16)
MASTER_IDX_WIDTH, 2, width of owner index; must equal ceil(log2(MASTER_NUM))
DEFAULT_MASTER, 0, master granted at reset and when no request is pending

Ports:
ahb_clk_in  input  1  AHB clock; all logic on its rising edge
ahb_rst_in  input  1  synchronous, active-high reset
ahb_req_in  input  MASTER_NUM  per-master bus request
ahb_lock_in  input  MASTER_NUM  per-master locked-sequence request
ahb_trans_in  input  2  HTRANS of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
ahb_burst_in  input  3  HBURST of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
ahb_ready_in  input  1  bus HREADY
ahb_grant_out  output  MASTER_NUM  one-hot grant, registered
ahb_master_out  output  MASTER_IDX_WIDTH  address-phase owner index (encodes ahb_grant_out)
ahb_data_master_out  output  MASTER_IDX_WIDTH  data-phase owner index
ahb_mastlock_out  output  1  current address phase belongs to a locked sequence

Behaviour:
- Reset (ahb_rst_in=1 at a clock edge):
  - ahb_grant_out = 1<<DEFAULT_MASTER
  - ahb_master_out = ahb_data_master_out = DEFAULT_MASTER
  - ahb_mastlock_out = 0
  - beat counter = 0, state = ST_OPEN, round-robin pointer = DEFAULT_MASTER
  - Reset mid-burst or mid-lock aborts immediately with the same values.
- ahb_ready_in=0: state, counter, grant, indices and mastlock are all frozen.
- Beat length from ahb_burst_in: WRAP4/INCR4 = 4, WRAP8/INCR8 = 8, WRAP16/INCR16 = 16. SINGLE and INCR are not fixed-length.
- Round-robin selection:
  - Search starts at (last granted + 1) mod MASTER_NUM and picks the first set ahb_req_in bit.
  - No request set: DEFAULT_MASTER.
  - Pointer updates only when the grant is re-issued.
- "Rearbitrate" means that at this edge, ahb_grant_out and ahb_master_out take the selection. The new owner drives its first address phase in the next cycle. The current owner may win again.
- ahb_data_master_out <= ahb_master_out on every edge with ahb_ready_in=1 (one-transfer pipeline lag).
- FSM states: ST_OPEN, ST_BURST, ST_LOCKED. All transitions require ahb_ready_in=1.
- ST_OPEN:
  - trans=NONSEQ with fixed-length burst: counter <= len-1, go ST_BURST, grant held.
  - Else, if ahb_lock_in[owner]=1: go ST_LOCKED, mastlock <= 1, grant held.
  - Else: rearbitrate, stay ST_OPEN.
  - INCR is therefore rearbitrable every beat, including BUSY beats.
- ST_BURST:
  - trans=SEQ: counter decrements. If counter was 1 (last beat accepted), rearbitrate (or go ST_LOCKED if lock is still asserted) and go ST_OPEN.
  - trans=BUSY: no change.
  - trans=IDLE or NONSEQ (early termination, e.g. after ERROR): counter <= 0; treat as ST_OPEN evaluation this same edge.
  - Requests from other masters are ignored until the burst ends.
- ST_LOCKED:
  - Grant held while ahb_lock_in[owner]=1. mastlock = 1, or 0 when trans=IDLE.
  - A fixed burst inside the lock uses the counter; the lock exit is not taken until the counter is 0.
  - First edge with lock low, counter 0 and trans != BUSY: mastlock <= 0, rearbitrate, go ST_OPEN.
- Simultaneous events: lock request plus other requests pending means lock wins for the current owner. Reset overrides everything.
- Latency: a request from an idle bus is granted at the next ready edge (1 cycle).

Test Plan:
- Reset, then all req=0 for 5 cycles, ready=1 -> grant=4'b0001, master=0, data_master=0, mastlock=0 throughout.
- req=4'b0110, owner 0 issues SINGLE NONSEQ, ready=1 -> next edge grant=4'b0010; with owner 1 doing SINGLEs and req held, following edge grant=4'b0100, then back to 4'b0010.
- Owner 1 NONSEQ INCR4 plus 3 SEQ, req[2]=1 throughout, ready stalls 2 cycles on beat 2 -> grant stays 4'b0010 until the edge accepting the 3rd SEQ, then grant=4'b0100; data_master=1 for one more ready cycle, then 2.
- Owner 0 INCR8 with BUSY inserted after beat 3, then IDLE after beat 5 -> grant unchanged across BUSY; rearbitration on the IDLE edge; counter=0.
- Owner 2 asserts lock with SINGLE transfers for 4 beats, req=4'b1011 -> grant fixed at 4'b0100 with mastlock=1; lock drops -> mastlock=0 and grant=4'b1000 on that edge.
- Reset asserted mid-INCR16 at counter=9 -> next edge grant=4'b0001, state ST_OPEN, counter=0, mastlock=0.
